// File: rtl/stride_pf_pkg.sv
// stride_pf_pkg: shared types for the multi-stream stride prefetcher.
// Entry field widths are fixed here; the top-level ADDR_BITS/CONF_BITS must match them.
package stride_pf_pkg;
  localparam int PF_ADDR_BITS = 64;
  localparam int PF_CONF_BITS = 2;
  typedef enum logic {IDLE, ISSUE} iss_state_e;
  typedef struct packed {
    logic                    vld;
    logic [PF_ADDR_BITS-1:0] last_addr;
    logic [PF_ADDR_BITS-1:0] stride;
    logic [PF_CONF_BITS-1:0] conf;
  } entry_t;
  function automatic int chan_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stride_pf_issuer.sv
// stride_pf_issuer: burst FSM that walks base+k*stride and presents each address on a valid/ready port.
// The running address is advanced by addition, so wrap is judged against the captured base.
module stride_pf_issuer
  import stride_pf_pkg::*;
#(
  parameter int ADDR_BITS = 64,
  parameter int CW        = 2,
  parameter int DEGREE    = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 flush_i,
  input  logic                 trig_i,
  input  logic [ADDR_BITS-1:0] trig_addr_i,
  input  logic [ADDR_BITS-1:0] trig_stride_i,
  input  logic [CW-1:0]        trig_chan_i,
  input  logic                 pf_ready_i,
  output logic                 pf_valid_o,
  output logic [ADDR_BITS-1:0] pf_addr_o,
  output logic [CW-1:0]        pf_chan_o,
  output logic                 trig_drop_o
);
  localparam int KW = $clog2(DEGREE + 1);
  localparam logic [KW-1:0] K_LAST = KW'(DEGREE);
  iss_state_e state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d, stride_q, stride_d, addr_q, addr_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [KW-1:0] k_q, k_d;
  logic wrap_q, wrap_d, drop_q, drop_d, hs, last, accept;
  function automatic logic wraps(input logic [ADDR_BITS-1:0] cand, base, stride);
    return stride[ADDR_BITS-1] ? (cand > base) : (cand < base);
  endfunction
  assign pf_valid_o  = (state_q == ISSUE) && !wrap_q;
  assign pf_addr_o   = addr_q;
  assign pf_chan_o   = chan_q;
  assign trig_drop_o = drop_q;
  assign hs     = pf_valid_o && pf_ready_i;
  assign last   = hs && (k_q == K_LAST);
  assign accept = trig_i && ((state_q == IDLE) || last);
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    stride_d = stride_q;
    chan_d   = chan_q;
    k_d      = k_q;
    addr_d   = addr_q;
    wrap_d   = wrap_q;
    drop_d   = trig_i && !accept && !flush_i;
    if (flush_i) begin
      state_d = IDLE;
      wrap_d  = 1'b0;
    end else if (accept) begin
      state_d  = ISSUE;
      base_d   = trig_addr_i;
      stride_d = trig_stride_i;
      chan_d   = trig_chan_i;
      k_d      = KW'(1);
      addr_d   = trig_addr_i + trig_stride_i;
      wrap_d   = wraps(addr_d, trig_addr_i, trig_stride_i);
    end else if ((state_q == ISSUE) && (wrap_q || last)) begin
      state_d = IDLE;
    end else if (hs) begin
      k_d    = k_q + 1'b1;
      addr_d = addr_q + stride_q;
      wrap_d = wraps(addr_d, base_q, stride_q);
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      base_q   <= '0;
      stride_q <= '0;
      chan_q   <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      chan_q   <= chan_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      wrap_q   <= wrap_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: rtl/multi_stride_prefetcher.sv
// multi_stride_prefetcher: per-channel stride/confidence table that triggers DEGREE-deep prefetch bursts.
// ADDR_BITS and CONF_BITS must equal PF_ADDR_BITS/PF_CONF_BITS because entries use the package struct.
module multi_stride_prefetcher
  import stride_pf_pkg::*;
#(
  parameter int ADDR_BITS   = PF_ADDR_BITS,
  parameter int BLOCK_BITS  = 6,
  parameter int CHANNELS    = 4,
  parameter int CONF_BITS   = PF_CONF_BITS,
  parameter int CONF_THRESH = 2,
  parameter int DEGREE      = 2,
  localparam int CW = chan_bits(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 acc_valid,
  input  logic [CW-1:0]        acc_chan,
  input  logic [ADDR_BITS-1:0] acc_addr,
  output logic                 pf_valid,
  input  logic                 pf_ready,
  output logic [ADDR_BITS-1:0] pf_addr,
  output logic [CW-1:0]        pf_chan,
  output logic                 trig_drop
);
  localparam logic [ADDR_BITS-1:0] BLK_MASK = {{(ADDR_BITS-BLOCK_BITS){1'b1}}, {BLOCK_BITS{1'b0}}};
  localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
  localparam logic [CONF_BITS-1:0] THR = CONF_BITS'(CONF_THRESH);
  entry_t tbl_q [CHANNELS];
  entry_t cur, ent_d;
  logic [ADDR_BITS-1:0] addr, delta;
  logic [CONF_BITS-1:0] conf_inc;
  logic upd, trig;
  assign upd      = acc_valid && en && !flush;
  assign cur      = tbl_q[acc_chan];
  assign addr     = acc_addr & BLK_MASK;
  assign delta    = addr - cur.last_addr;
  assign conf_inc = (cur.conf == CONF_MAX) ? cur.conf : cur.conf + 1'b1;
  always_comb begin
    ent_d = cur;
    trig  = 1'b0;
    if (!cur.vld) begin
      ent_d = '{vld: 1'b1, last_addr: addr, stride: '0, conf: '0};
    end else if (delta != '0) begin
      ent_d.last_addr = addr;
      if (delta == cur.stride) begin
        ent_d.conf = conf_inc;
        trig       = upd && (conf_inc >= THR);
      end else if (cur.conf >= THR) begin
        ent_d.conf = cur.conf - 1'b1;
      end else begin
        ent_d.stride = delta;
        ent_d.conf   = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < CHANNELS; i++) tbl_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < CHANNELS; i++) tbl_q[i] <= '0;
    end else if (upd) begin
      tbl_q[acc_chan] <= ent_d;
    end
  end
  // A trigger only fires on a stride match, so the entry's current stride is the burst stride.
  stride_pf_issuer #(
    .ADDR_BITS(ADDR_BITS),
    .CW       (CW),
    .DEGREE   (DEGREE)
  ) u_issuer (
    .clk          (clk),
    .resetN       (resetN),
    .flush_i      (flush),
    .trig_i       (trig),
    .trig_addr_i  (addr),
    .trig_stride_i(cur.stride),
    .trig_chan_i  (acc_chan),
    .pf_ready_i   (pf_ready),
    .pf_valid_o   (pf_valid),
    .pf_addr_o    (pf_addr),
    .pf_chan_o    (pf_chan),
    .trig_drop_o  (trig_drop)
  );
endmodule

// File: tb/tb_multi_stride_prefetcher.sv
// tb_multi_stride_prefetcher: directed scenarios with a queue of expected prefetch requests.
module tb_multi_stride_prefetcher;
  logic        clk = 1'b0;
  logic        resetN, en, flush, acc_valid, pf_valid, pf_ready, trig_drop;
  logic [1:0]  acc_chan, pf_chan;
  logic [63:0] acc_addr, pf_addr;
  logic [65:0] exp_q[$];
  logic [65:0] e_req;
  int          errors = 0;
  int          checks = 0;

  multi_stride_prefetcher dut (
    .clk      (clk),
    .resetN   (resetN),
    .en       (en),
    .flush    (flush),
    .acc_valid(acc_valid),
    .acc_chan (acc_chan),
    .acc_addr (acc_addr),
    .pf_valid (pf_valid),
    .pf_ready (pf_ready),
    .pf_addr  (pf_addr),
    .pf_chan  (pf_chan),
    .trig_drop(trig_drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetN && pf_valid && pf_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pf_unexpected: got addr=%h chan=%0d, required no request", pf_addr, pf_chan);
      end
      if (exp_q.size() > 0) begin
        e_req = exp_q.pop_front();
        checks++;
        assert ({pf_addr, pf_chan} === e_req) else begin
          errors++;
          $error("FAIL pf_req: got addr=%h chan=%0d, required addr=%h chan=%0d",
                 pf_addr, pf_chan, e_req[65:2], e_req[1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] req);
    checks++;
    assert (got === req) else begin
      errors++;
      $error("FAIL %s: got %h, required %h", tag, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [1:0] c, input logic [63:0] a);
    acc_valid = 1'b1;
    acc_chan  = c;
    acc_addr  = a;
    step();
    acc_valid = 1'b0;
  endtask

  task automatic push(input logic [63:0] a, input logic [1:0] c);
    exp_q.push_back({a, c});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: %0d prefetches still outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    resetN = 1'b0; en = 1'b1; flush = 1'b0; acc_valid = 1'b0;
    acc_chan = 2'd0; acc_addr = '0; pf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pf_valid", {63'd0, pf_valid}, 64'd0);
    chk("rst_pf_addr", pf_addr, 64'd0);
    chk("rst_pf_chan", {62'd0, pf_chan}, 64'd0);
    chk("rst_trig_drop", {63'd0, trig_drop}, 64'd0);
    resetN = 1'b1;
    step();

    // ascending stride +0x40 on channel 0
    pf_ready = 1'b1;
    push(64'h1100, 2'd0);
    push(64'h1140, 2'd0);
    acc(2'd0, 64'h1000);
    acc(2'd0, 64'h1040);
    acc(2'd0, 64'h1080);
    @(negedge clk);
    chk("no_pf_before_conf", {63'd0, pf_valid}, 64'd0);
    @(posedge clk); #1;
    acc(2'd0, 64'h10C0);
    @(negedge clk);
    chk("first_pf_latency", {63'd0, pf_valid}, 64'd1);
    @(posedge clk); #1;
    drain("asc_burst");
    @(negedge clk);
    chk("idle_after_burst", {63'd0, pf_valid}, 64'd0);
    @(posedge clk); #1;

    // descending stride -0x40 on channel 2
    push(64'h1F00, 2'd2);
    push(64'h1EC0, 2'd2);
    acc(2'd2, 64'h2000);
    acc(2'd2, 64'h1FC0);
    acc(2'd2, 64'h1F80);
    acc(2'd2, 64'h1F40);
    drain("desc_burst");

    // stall: ready low for 3 cycles, request held stable
    pf_ready = 1'b0;
    acc(2'd3, 64'h1000);
    acc(2'd3, 64'h1040);
    acc(2'd3, 64'h1080);
    acc(2'd3, 64'h10C0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'd0, pf_valid}, 64'd1);
      chk("stall_addr", pf_addr, 64'h1100);
      chk("stall_chan", {62'd0, pf_chan}, 64'd3);
      @(posedge clk); #1;
    end
    push(64'h1100, 2'd3);
    push(64'h1140, 2'd3);
    pf_ready = 1'b1;
    drain("stall_burst");

    // chan 1 trigger dropped while chan 0 burst stalls
    pf_ready = 1'b0;
    acc(2'd0, 64'h1100);
    acc(2'd1, 64'h3000);
    acc(2'd1, 64'h3040);
    acc(2'd1, 64'h3080);
    @(negedge clk);
    chk("no_drop_yet", {63'd0, trig_drop}, 64'd0);
    @(posedge clk); #1;
    acc(2'd1, 64'h30C0);
    @(negedge clk);
    chk("trig_drop_pulse", {63'd0, trig_drop}, 64'd1);
    chk("busy_chan", {62'd0, pf_chan}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trig_drop_one_cycle", {63'd0, trig_drop}, 64'd0);
    push(64'h1140, 2'd0);
    push(64'h1180, 2'd0);
    pf_ready = 1'b1;
    @(posedge clk); #1;
    drain("drop_burst");

    // conf=3 entry mismatches: conf drops to 2 and stride survives, so the next match retriggers
    acc(2'd0, 64'h5000);
    push(64'h5080, 2'd0);
    push(64'h50C0, 2'd0);
    acc(2'd0, 64'h5040);
    drain("conf_keep_stride");

    // wrap at the top of the address space on channel 2
    push(64'hFFFF_FFFF_FFFF_FFC0, 2'd2);
    acc(2'd2, 64'hFFFF_FFFF_FFFF_FEC0);
    acc(2'd2, 64'hFFFF_FFFF_FFFF_FF00);
    acc(2'd2, 64'hFFFF_FFFF_FFFF_FF40);
    acc(2'd2, 64'hFFFF_FFFF_FFFF_FF80);
    drain("wrap_first");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("wrap_suppressed", {63'd0, pf_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // reset mid-burst
    pf_ready = 1'b0;
    acc(2'd0, 64'h5080);
    @(negedge clk);
    chk("pre_reset_valid", {63'd0, pf_valid}, 64'd1);
    #1 resetN = 1'b0;
    #1;
    chk("reset_async_valid", {63'd0, pf_valid}, 64'd0);
    chk("reset_async_addr", pf_addr, 64'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    pf_ready = 1'b1;
    acc(2'd0, 64'h5100);
    acc(2'd0, 64'h5140);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_reset_no_pf", {63'd0, pf_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // flush aborts a stalled burst and invalidates the table
    pf_ready = 1'b0;
    acc(2'd0, 64'h5180);
    acc(2'd0, 64'h51C0);
    @(negedge clk);
    chk("pre_flush_valid", {63'd0, pf_valid}, 64'd1);
    chk("pre_flush_addr", pf_addr, 64'h5200);
    @(posedge clk); #1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", {63'd0, pf_valid}, 64'd0);
    @(posedge clk); #1;
    pf_ready = 1'b1;
    acc(2'd0, 64'h5200);
    acc(2'd0, 64'h5240);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_flush_no_pf", {63'd0, pf_valid}, 64'd0);
      @(posedge clk); #1;
    end

    repeat (3) step();
    chk("queue_empty", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
